dma_engine: RTL and testbench



---
 rtl/dma_engine_pkg.sv | 40 ++++
 rtl/dma_engine.sv | 213 +++++++++++++++++++++
 tb/tb_dma_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_engine_pkg.sv
// Shared widths, register map, bit indices and types for the DMA engine.
package dma_engine_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned XLEN   = 32;

   localparam logic [ADDR_W-1:0] DMA_BASE_ADDR   = 32'h4000_0000;

   localparam logic [ADDR_W-1:0] DMA_SRC_OFFSET  = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] DMA_DST_OFFSET  = 32'h0000_0004;
   localparam logic [ADDR_W-1:0] DMA_LEN_OFFSET  = 32'h0000_0008;
   localparam logic [ADDR_W-1:0] DMA_CTRL_OFFSET = 32'h0000_000C;
   localparam logic [ADDR_W-1:0] DMA_STAT_OFFSET = 32'h0000_0010;
   localparam logic [ADDR_W-1:0] DMA_CLR_OFFSET  = 32'h0000_0014;

   localparam int unsigned DMA_CTRL_START_BIT  = 0;
   localparam int unsigned DMA_CTRL_IRQ_EN_BIT = 1;
   localparam int unsigned DMA_STAT_BUSY_BIT   = 0;
   localparam int unsigned DMA_STAT_DONE_BIT   = 1;
   localparam int unsigned DMA_STAT_ERR_BIT    = 2;
   localparam int unsigned DMA_CLR_DONE_BIT    = 0;
   localparam int unsigned DMA_CLR_ERR_BIT     = 1;

   // Copy FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } dma_state_e;

   // Bus-master request payload
   typedef struct packed {
      logic              req;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   wdata;
   } dma_bus_t;

endpackage

// File: rtl/dma_engine.sv
// Memory-to-memory word-copy DMA engine with MMIO register block and bus master.
module dma_engine
   import dma_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mmio_req,
   input  logic              mmio_we,
   input  logic [ADDR_W-1:0] mmio_addr,
   input  logic [XLEN-1:0]   mmio_wdata,
   output logic [XLEN-1:0]   mmio_rdata,
   output logic              mmio_ready,
   output logic              dma_mem_req,
   output logic              dma_mem_we,
   output logic [ADDR_W-1:0] dma_mem_addr,
   output logic [XLEN-1:0]   dma_mem_wdata,
   input  logic [XLEN-1:0]   dma_mem_rdata,
   input  logic              dma_mem_ready,
   output logic              dma_irq
);

   localparam int unsigned REM_W = ADDR_W - 2;

   // Programmed registers and status
   logic [ADDR_W-1:0] r_src, r_dst, r_len;
   logic              r_irq_en, r_done, r_err, r_irq, r_irq_arm;
   // Transfer working state
   dma_state_e        r_state;
   logic [ADDR_W-1:0] r_cur_src, r_cur_dst;
   logic [REM_W-1:0]  r_remain;
   logic [XLEN-1:0]   r_buf;
   dma_bus_t          r_bus;

   // Next-state values
   logic [ADDR_W-1:0] w_src_nxt, w_dst_nxt, w_len_nxt;
   logic              w_irq_en_nxt, w_done_nxt, w_err_nxt, w_irq_nxt, w_irq_arm_nxt;
   dma_state_e        w_state_nxt;
   logic [ADDR_W-1:0] w_cur_src_nxt, w_cur_dst_nxt;
   logic [REM_W-1:0]  w_remain_nxt;
   logic [XLEN-1:0]   w_buf_nxt;
   dma_bus_t          w_bus_nxt;

   logic [2:0] w_idx;
   logic       w_wr;
   logic       w_busy;
   logic       w_bad_align;
   logic       w_unused_addr;

   assign w_idx         = mmio_addr[4:2];
   assign w_wr          = mmio_req & mmio_we;
   assign w_busy        = (r_state != ST_IDLE);
   assign w_bad_align   = |{r_len[1:0], r_src[1:0], r_dst[1:0]};
   assign w_unused_addr = ^{mmio_addr[ADDR_W-1:5], mmio_addr[1:0]};

   assign mmio_ready    = mmio_req;
   assign dma_mem_req   = r_bus.req;
   assign dma_mem_we    = r_bus.we;
   assign dma_mem_addr  = r_bus.addr;
   assign dma_mem_wdata = r_bus.wdata;
   assign dma_irq       = r_irq;

   // Combinational register readback
   always_comb begin
      mmio_rdata = '0;
      case (w_idx)
         DMA_SRC_OFFSET[4:2]:  mmio_rdata = r_src;
         DMA_DST_OFFSET[4:2]:  mmio_rdata = r_dst;
         DMA_LEN_OFFSET[4:2]:  mmio_rdata = r_len;
         DMA_CTRL_OFFSET[4:2]: mmio_rdata[DMA_CTRL_IRQ_EN_BIT] = r_irq_en;
         DMA_STAT_OFFSET[4:2]: begin
            mmio_rdata[DMA_STAT_BUSY_BIT] = w_busy;
            mmio_rdata[DMA_STAT_DONE_BIT] = r_done;
            mmio_rdata[DMA_STAT_ERR_BIT]  = r_err;
         end
         default: mmio_rdata = '0;
      endcase
   end

   // Next-state: register writes, START/CLR handling, copy FSM, master outputs
   always_comb begin
      w_src_nxt     = r_src;
      w_dst_nxt     = r_dst;
      w_len_nxt     = r_len;
      w_irq_en_nxt  = r_irq_en;
      w_done_nxt    = r_done;
      w_err_nxt     = r_err;
      w_irq_nxt     = r_irq;
      w_irq_arm_nxt = r_irq_arm;
      w_state_nxt   = r_state;
      w_cur_src_nxt = r_cur_src;
      w_cur_dst_nxt = r_cur_dst;
      w_remain_nxt  = r_remain;
      w_buf_nxt     = r_buf;
      w_bus_nxt     = r_bus;

      // Configuration writes are locked out while a copy is running
      if (w_wr && !w_busy) begin
         case (w_idx)
            DMA_SRC_OFFSET[4:2]: w_src_nxt = mmio_wdata;
            DMA_DST_OFFSET[4:2]: w_dst_nxt = mmio_wdata;
            DMA_LEN_OFFSET[4:2]: w_len_nxt = mmio_wdata;
            DMA_CTRL_OFFSET[4:2]: begin
               w_irq_en_nxt = mmio_wdata[DMA_CTRL_IRQ_EN_BIT];
               if (mmio_wdata[DMA_CTRL_START_BIT]) begin
                  w_done_nxt    = 1'b0;
                  w_err_nxt     = 1'b0;
                  w_irq_nxt     = 1'b0;
                  w_irq_arm_nxt = mmio_wdata[DMA_CTRL_IRQ_EN_BIT];
                  if (w_bad_align) begin
                     w_err_nxt  = 1'b1;
                     w_done_nxt = 1'b1;
                  end else if (r_len == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt   = ST_READ;
                     w_cur_src_nxt = r_src;
                     w_cur_dst_nxt = r_dst;
                     w_remain_nxt  = r_len[ADDR_W-1:2];
                  end
               end
            end
            default: ;
         endcase
      end

      // W1C status clear; evaluated before FINISH so a same-cycle completion wins
      if (w_wr && (w_idx == DMA_CLR_OFFSET[4:2])) begin
         if (mmio_wdata[DMA_CLR_DONE_BIT]) begin
            w_done_nxt = 1'b0;
            w_irq_nxt  = 1'b0;
         end
         if (mmio_wdata[DMA_CLR_ERR_BIT]) w_err_nxt = 1'b0;
      end

      case (r_state)
         ST_READ: begin
            if (dma_mem_ready) begin
               w_buf_nxt   = dma_mem_rdata;
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (dma_mem_ready) begin
               w_cur_src_nxt = r_cur_src + ADDR_W'(4);
               w_cur_dst_nxt = r_cur_dst + ADDR_W'(4);
               w_remain_nxt  = r_remain - REM_W'(1);
               w_state_nxt   = (r_remain == REM_W'(1)) ? ST_FINISH : ST_READ;
            end
         end
         ST_FINISH: begin
            w_done_nxt  = 1'b1;
            if (r_irq_arm) w_irq_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: ;
      endcase

      // Master outputs registered from the upcoming state; held while stalled
      case (w_state_nxt)
         ST_READ: begin
            w_bus_nxt.req  = 1'b1;
            w_bus_nxt.we   = 1'b0;
            w_bus_nxt.addr = w_cur_src_nxt;
         end
         ST_WRITE: begin
            w_bus_nxt.req   = 1'b1;
            w_bus_nxt.we    = 1'b1;
            w_bus_nxt.addr  = w_cur_dst_nxt;
            w_bus_nxt.wdata = w_buf_nxt;
         end
         default: begin
            w_bus_nxt.req = 1'b0;
            w_bus_nxt.we  = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_irq_en  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_irq     <= 1'b0;
         r_irq_arm <= 1'b0;
         r_state   <= ST_IDLE;
         r_cur_src <= '0;
         r_cur_dst <= '0;
         r_remain  <= '0;
         r_buf     <= '0;
         r_bus     <= '0;
      end else begin
         r_src     <= w_src_nxt;
         r_dst     <= w_dst_nxt;
         r_len     <= w_len_nxt;
         r_irq_en  <= w_irq_en_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_irq     <= w_irq_nxt;
         r_irq_arm <= w_irq_arm_nxt;
         r_state   <= w_state_nxt;
         r_cur_src <= w_cur_src_nxt;
         r_cur_dst <= w_cur_dst_nxt;
         r_remain  <= w_remain_nxt;
         r_buf     <= w_buf_nxt;
         r_bus     <= w_bus_nxt;
      end
   end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with a 4 KB word memory behind the master port.
module tb_dma_engine;
   import dma_engine_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mmio_req, mmio_we;
   logic [ADDR_W-1:0] mmio_addr;
   logic [XLEN-1:0]   mmio_wdata, mmio_rdata;
   logic              mmio_ready;
   logic              dma_mem_req, dma_mem_we, dma_mem_ready;
   logic [ADDR_W-1:0] dma_mem_addr;
   logic [XLEN-1:0]   dma_mem_wdata, dma_mem_rdata;
   logic              dma_irq;

   logic [31:0] mem [0:1023];
   logic        bd_we;
   logic [9:0]  bd_idx;
   logic [31:0] bd_data;

   int n_assert = 0;
   int n_fail   = 0;
   int req_cnt  = 0;

   logic        stall_prev = 1'b0;
   logic [65:0] snap;

   always #5 clk = ~clk;

   dma_engine u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mmio_req      (mmio_req),
      .mmio_we       (mmio_we),
      .mmio_addr     (mmio_addr),
      .mmio_wdata    (mmio_wdata),
      .mmio_rdata    (mmio_rdata),
      .mmio_ready    (mmio_ready),
      .dma_mem_req   (dma_mem_req),
      .dma_mem_we    (dma_mem_we),
      .dma_mem_addr  (dma_mem_addr),
      .dma_mem_wdata (dma_mem_wdata),
      .dma_mem_rdata (dma_mem_rdata),
      .dma_mem_ready (dma_mem_ready),
      .dma_irq       (dma_irq)
   );

   // Memory model: combinational read, write on handshake, plus a backdoor preload port
   assign dma_mem_rdata = mem[dma_mem_addr[11:2]];
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (dma_mem_req && dma_mem_we && dma_mem_ready) mem[dma_mem_addr[11:2]] <= dma_mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Bus monitor: address legality and stability of a stalled request
   always @(negedge clk) begin
      if (rst_n) begin
         if (dma_mem_req) begin
            req_cnt++;
            check("bus_addr_legal", {31'd0, (dma_mem_addr[31:12] == 20'd0) && (dma_mem_addr[1:0] == 2'd0)}, 32'd1);
         end
         if (stall_prev) begin
            n_assert++;
            assert ({dma_mem_req, dma_mem_we, dma_mem_addr, dma_mem_wdata} === snap) else begin
               n_fail++;
               $error("FAIL stall_stable: observed %h expected %h",
                      {dma_mem_req, dma_mem_we, dma_mem_addr, dma_mem_wdata}, snap);
            end
         end
         snap       = {dma_mem_req, dma_mem_we, dma_mem_addr, dma_mem_wdata};
         stall_prev = dma_mem_req && !dma_mem_ready;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input int idx, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_idx  = 10'(idx);
      bd_data = d;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic mmio_wr(input logic [31:0] off, input logic [31:0] d);
      mmio_req   = 1'b1;
      mmio_we    = 1'b1;
      mmio_addr  = DMA_BASE_ADDR + off;
      mmio_wdata = d;
      tick();
      mmio_req   = 1'b0;
      mmio_we    = 1'b0;
   endtask

   task automatic mmio_rd(input logic [31:0] off, output logic [31:0] d);
      mmio_req  = 1'b1;
      mmio_we   = 1'b0;
      mmio_addr = DMA_BASE_ADDR + off;
      #1;
      d = mmio_rdata;
      tick();
      mmio_req  = 1'b0;
   endtask

   // Poll STAT until DONE, optionally throttling the memory ready
   task automatic wait_done(input bit rnd, output logic [31:0] s);
      s = '0;
      for (int i = 0; i < 5000; i++) begin
         if (rnd) dma_mem_ready = ($urandom_range(0, 3) != 0);
         mmio_rd(DMA_STAT_OFFSET, s);
         if (s[DMA_STAT_DONE_BIT]) break;
      end
      dma_mem_ready = 1'b1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_data [0:15];
      int c0;

      rst_n = 1'b0; mmio_req = 1'b0; mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0;
      dma_mem_ready = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;

      // Reset state
      repeat (3) tick();
      check("rst_req",   {31'd0, dma_mem_req}, 32'd0);
      check("rst_we",    {31'd0, dma_mem_we}, 32'd0);
      check("rst_addr",  dma_mem_addr, 32'd0);
      check("rst_wdata", dma_mem_wdata, 32'd0);
      check("rst_irq",   {31'd0, dma_irq}, 32'd0);
      rst_n = 1'b1;
      tick();
      mmio_rd(DMA_STAT_OFFSET, rd); check("rst_stat", rd, 32'd0);
      mmio_rd(DMA_SRC_OFFSET, rd);  check("rst_src", rd, 32'd0);
      mmio_rd(DMA_LEN_OFFSET, rd);  check("rst_len", rd, 32'd0);

      // Copy of 4 words with IRQ enabled, ready tied high
      for (int i = 0; i < 4; i++) begin
         bd_write(64 + i, 32'hA5A5_0000 + 32'(i));
         bd_write(128 + i, 32'hDEAD_BEEF);
      end
      mmio_wr(DMA_SRC_OFFSET, 32'h100);
      mmio_wr(DMA_DST_OFFSET, 32'h200);
      mmio_wr(DMA_LEN_OFFSET, 32'd16);
      mmio_wr(DMA_CTRL_OFFSET, 32'h3);
      check("first_req",  {31'd0, dma_mem_req}, 32'd1);
      check("first_we",   {31'd0, dma_mem_we}, 32'd0);
      check("first_addr", dma_mem_addr, 32'h100);
      repeat (7) tick();
      check("last_wr_addr",  dma_mem_addr, 32'h20C);
      check("last_wr_data",  dma_mem_wdata, 32'hA5A5_0003);
      check("last_wr_we",    {31'd0, dma_mem_we}, 32'd1);
      tick();
      check("irq_in_finish", {31'd0, dma_irq}, 32'd0);
      tick();
      check("irq_after_finish", {31'd0, dma_irq}, 32'd1);
      mmio_rd(DMA_STAT_OFFSET, rd); check("copy_stat", rd, 32'h2);
      for (int i = 0; i < 4; i++)
         check($sformatf("copy_dst%0d", i), mem[128 + i], 32'hA5A5_0000 + 32'(i));
      repeat (8) tick();
      check("irq_idle", {31'd0, dma_irq}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         mmio_rd(DMA_STAT_OFFSET, rd);
         check("irq_stat_read", {31'd0, dma_irq}, 32'd1);
      end
      mmio_wr(DMA_CTRL_OFFSET, 32'h0);
      check("irq_ctrl_wr", {31'd0, dma_irq}, 32'd1);
      mmio_rd(DMA_SRC_OFFSET, rd); check("src_readback", rd, 32'h100);
      mmio_rd(DMA_DST_OFFSET, rd); check("dst_readback", rd, 32'h200);
      mmio_rd(DMA_LEN_OFFSET, rd); check("len_readback", rd, 32'd16);
      mmio_wr(DMA_CLR_OFFSET, 32'h3);
      mmio_rd(DMA_STAT_OFFSET, rd); check("clr_stat", rd, 32'h0);
      check("clr_irq", {31'd0, dma_irq}, 32'd0);

      // Zero length: DONE at the START edge, no traffic
      c0 = req_cnt;
      mmio_wr(DMA_LEN_OFFSET, 32'd0);
      mmio_wr(DMA_CTRL_OFFSET, 32'h1);
      mmio_rd(DMA_STAT_OFFSET, rd); check("len0_stat", rd, 32'h2);
      repeat (3) tick();
      check("len0_no_req", 32'(req_cnt - c0), 32'd0);

      // Misaligned length: DONE+ERR, no traffic, CLR clears both
      c0 = req_cnt;
      mmio_wr(DMA_LEN_OFFSET, 32'd6);
      mmio_wr(DMA_CTRL_OFFSET, 32'h1);
      mmio_rd(DMA_STAT_OFFSET, rd); check("len6_stat", rd, 32'h6);
      repeat (3) tick();
      check("len6_no_req", 32'(req_cnt - c0), 32'd0);
      mmio_wr(DMA_CLR_OFFSET, 32'h3);
      mmio_rd(DMA_STAT_OFFSET, rd); check("len6_clr", rd, 32'h0);

      // Writes and START while BUSY are ignored
      for (int i = 0; i < 8; i++) begin
         bd_write(i, 32'h1234_0000 + 32'(i * 7));
         bd_write(512 + i, 32'h0);
      end
      mmio_wr(DMA_SRC_OFFSET, 32'h000);
      mmio_wr(DMA_DST_OFFSET, 32'h800);
      mmio_wr(DMA_LEN_OFFSET, 32'd32);
      dma_mem_ready = 1'b0;
      mmio_wr(DMA_CTRL_OFFSET, 32'h1);
      mmio_wr(DMA_SRC_OFFSET, 32'h444);
      mmio_rd(DMA_SRC_OFFSET, rd);  check("busy_src_ignored", rd, 32'h000);
      mmio_rd(DMA_STAT_OFFSET, rd); check("busy_stat", rd, 32'h1);
      mmio_wr(DMA_CTRL_OFFSET, 32'h3);
      mmio_wr(DMA_LEN_OFFSET, 32'd4);
      mmio_rd(DMA_LEN_OFFSET, rd);  check("busy_len_ignored", rd, 32'd32);
      mmio_rd(DMA_CTRL_OFFSET, rd); check("busy_ctrl_ignored", rd, 32'h0);
      check("busy_stalled_addr", dma_mem_addr, 32'h000);
      dma_mem_ready = 1'b1;
      wait_done(1'b0, rd);
      check("busy_done_stat", rd, 32'h2);
      check("busy_irq", {31'd0, dma_irq}, 32'd0);
      for (int i = 0; i < 8; i++)
         check($sformatf("busy_dst%0d", i), mem[512 + i], 32'h1234_0000 + 32'(i * 7));
      mmio_wr(DMA_CLR_OFFSET, 32'h1);

      // Random copies with a throttled memory
      for (int t = 0; t < 50; t++) begin
         int nw, si, di;
         nw = int'($urandom_range(1, 16));
         si = int'($urandom_range(0, 512 - nw));
         di = 512 + int'($urandom_range(0, 512 - nw));
         for (int w = 0; w < nw; w++) begin
            exp_data[w] = $urandom;
            bd_write(si + w, exp_data[w]);
            bd_write(di + w, ~exp_data[w]);
         end
         mmio_wr(DMA_SRC_OFFSET, 32'(si * 4));
         mmio_wr(DMA_DST_OFFSET, 32'(di * 4));
         mmio_wr(DMA_LEN_OFFSET, 32'(nw * 4));
         mmio_wr(DMA_CTRL_OFFSET, 32'h1);
         wait_done(1'b1, rd);
         check($sformatf("rnd%0d_stat", t), rd, 32'h2);
         for (int w = 0; w < nw; w++)
            check($sformatf("rnd%0d_w%0d", t, w), mem[di + w], exp_data[w]);
         mmio_wr(DMA_CLR_OFFSET, 32'h1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
